mcu_builder: RTL and testbench

MCU_BUILDER -- requirements
Module: mcu_builder

---
 rtl/jpeg_pkg.sv | 37 +++
 rtl/mcu_builder_rgb2ycbcr.sv | 48 ++++
 rtl/mcu_builder.sv | 200 ++++++++++++++++++++
 tb/tb_mcu_builder.sv | 195 +++++++++++++++++++
 4 files changed

// File: rtl/jpeg_pkg.sv
// Shared JPEG front-end constants: component codes, RGB->YCbCr coefficients,
// rounding, MCU sizes and the 8-bit chroma saturation helper.
package jpeg_pkg;

   localparam logic [1:0] COMP_Y  = 2'd0;
   localparam logic [1:0] COMP_CB = 2'd1;
   localparam logic [1:0] COMP_CR = 2'd2;

   localparam logic signed [19:0] K_Y_R    = 20'sd306;
   localparam logic signed [19:0] K_Y_G    = 20'sd601;
   localparam logic signed [19:0] K_Y_B    = 20'sd117;
   localparam logic signed [19:0] K_CB_R   = 20'sd173;
   localparam logic signed [19:0] K_CB_G   = 20'sd339;
   localparam logic signed [19:0] K_C_HALF = 20'sd512;
   localparam logic signed [19:0] K_CR_G   = 20'sd429;
   localparam logic signed [19:0] K_CR_B   = 20'sd83;
   localparam logic signed [19:0] RND      = 20'sd512;
   localparam int                 FRAC_BITS = 10;

   localparam int MCU444_PIX = 64;
   localparam int MCU420_PIX = 256;
   localparam int MCU444_SMP = 192;
   localparam int MCU420_SMP = 384;

   typedef struct packed {
      logic [1:0] comp;
      logic [1:0] idx;
      logic [5:0] pos;
   } blk_tag_t;

   function automatic logic signed [7:0] sat8(input logic signed [11:0] v);
      if (v > 12'sd127)       return 8'sd127;
      else if (v < -12'sd128) return -8'sd128;
      else                    return v[7:0];
   endfunction

endpackage

// File: rtl/mcu_builder_rgb2ycbcr.sv
// RGB -> level-shifted YCbCr in one registered stage: luma as Y-128,
// chroma saturated to [-128,127].
module rgb2ycbcr
   import jpeg_pkg::*;
(
   input  logic              clk,
   input  logic              rst,
   input  logic              in_valid,
   input  logic [7:0]        r,
   input  logic [7:0]        g,
   input  logic [7:0]        b,
   output logic              out_valid,
   output logic signed [7:0] y,
   output logic signed [7:0] cb,
   output logic signed [7:0] cr
);

   logic signed [19:0] rs, gs, bs;
   logic signed [19:0] y_shr, cb_shr, cr_shr;
   logic               unused_bits;

   always_comb begin
      rs     = signed'({12'd0, r});
      gs     = signed'({12'd0, g});
      bs     = signed'({12'd0, b});
      y_shr  = (K_Y_R * rs + K_Y_G * gs + K_Y_B * bs + RND) >>> FRAC_BITS;
      cb_shr = (K_C_HALF * bs - K_CB_R * rs - K_CB_G * gs + RND) >>> FRAC_BITS;
      cr_shr = (K_C_HALF * rs - K_CR_G * gs - K_CR_B * bs + RND) >>> FRAC_BITS;
   end

   // Luma is always 0..255, so subtracting 128 is just flipping the MSB.
   assign unused_bits = ^{y_shr[19:8], cb_shr[19:12], cr_shr[19:12]};

   always_ff @(posedge clk) begin
      if (rst) begin
         out_valid <= 1'b0;
         y         <= '0;
         cb        <= '0;
         cr        <= '0;
      end else begin
         out_valid <= in_valid;
         y         <= {~y_shr[7], y_shr[6:0]};
         cb        <= sat8(cb_shr[11:0]);
         cr        <= sat8(cr_shr[11:0]);
      end
   end

endmodule

// File: rtl/mcu_builder.sv
// Collects one MCU of RGB pixels, converts to YCbCr and streams 8x8 blocks
// Y0[..Y3],Cb,Cr to the DCT. 4:2:0 support is built only with MCU_BUILDER_420_EN.
module mcu_builder
   import jpeg_pkg::*;
(
   input  logic        clk,
   input  logic        rst,
   input  logic        mode_420,
   input  logic [7:0]  pix_r,
   input  logic [7:0]  pix_g,
   input  logic [7:0]  pix_b,
   input  logic        pix_valid,
   output logic        pix_ready,
   output logic [15:0] blk_data,
   output logic [1:0]  blk_comp,
   output logic [1:0]  blk_idx,
   output logic [5:0]  blk_pos,
   output logic        blk_valid,
   input  logic        blk_ready,
   output logic        blk_last,
   output logic        mcu_done,
   output logic [1:0]  fsm_state
);

   // Handshakes: a pixel moves on a rising edge with pix_valid && pix_ready,
   // a sample moves with blk_valid && blk_ready; outputs hold while stalled.
   localparam logic [1:0] ST_FILL   = 2'd0;
   localparam logic [1:0] ST_SETTLE = 2'd1;
   localparam logic [1:0] ST_PRIME  = 2'd2;
   localparam logic [1:0] ST_DRAIN  = 2'd3;

`ifdef MCU_BUILDER_420_EN
   localparam int PC_W = 8;
   localparam int C_W  = 10;
`else
   localparam int PC_W = 6;
   localparam int C_W  = 8;
`endif

   logic [1:0]              state;
   logic [PC_W-1:0]         pix_cnt, y_wa, wr_ya;
   logic [5:0]              c_wa, wr_ca;
   logic [8:0]              smp_cnt, smp_nxt;
   logic [2:0]              c_blk;
   logic                    mode_cur, mode_m, pix_fire, pix_last, smp_last;
   logic                    conv_v;
   logic signed [7:0]       conv_y, conv_cb, conv_cr, y_rd, c_s8, rd_s8;
   logic signed [C_W-1:0]   c_sel;
   blk_tag_t                rd_tag;
   logic signed [7:0]       y_mem  [0:(1<<PC_W)-1];
   logic signed [C_W-1:0]   cb_mem [0:63];
   logic signed [C_W-1:0]   cr_mem [0:63];

`ifdef MCU_BUILDER_420_EN
   logic                    mode_q, c_first, wr_first, wr_mode;
   logic signed [C_W-1:0]   cb_ext, cr_ext;
   logic signed [11:0]      c_avg;

   always_ff @(posedge clk) begin
      if (rst)                             mode_q <= 1'b0;
      else if (pix_fire && pix_cnt == '0)  mode_q <= mode_420;
   end
   assign mode_cur = (pix_cnt == '0) ? mode_420 : mode_q;
   assign mode_m   = mode_q;
   assign cb_ext   = {{(C_W-8){conv_cb[7]}}, conv_cb};
   assign cr_ext   = {{(C_W-8){conv_cr[7]}}, conv_cr};
`else
   logic unused_mode;
   assign unused_mode = mode_420;
   assign mode_cur    = 1'b0;
   assign mode_m      = 1'b0;
`endif

   assign pix_ready = (state == ST_FILL);
   assign blk_valid = (state == ST_DRAIN);
   assign fsm_state = state;

   always_comb begin
      pix_fire = pix_valid && pix_ready;
      pix_last = (pix_cnt == PC_W'(MCU444_PIX - 1));
      y_wa     = pix_cnt;
      c_wa     = pix_cnt[5:0];
`ifdef MCU_BUILDER_420_EN
      c_first  = 1'b1;
      // 16x16 raster: count = {row[3:0], col[3:0]}; quadrant picks the Y block.
      if (mode_cur) begin
         pix_last = (pix_cnt == PC_W'(MCU420_PIX - 1));
         y_wa     = {pix_cnt[7], pix_cnt[3], pix_cnt[6:4], pix_cnt[2:0]};
         c_wa     = {pix_cnt[7:5], pix_cnt[3:1]};
         c_first  = !pix_cnt[4] && !pix_cnt[0];
      end
`endif
   end

   rgb2ycbcr u_csc (
      .clk       (clk),
      .rst       (rst),
      .in_valid  (pix_fire),
      .r         (pix_r),
      .g         (pix_g),
      .b         (pix_b),
      .out_valid (conv_v),
      .y         (conv_y),
      .cb        (conv_cb),
      .cr        (conv_cr)
   );

   always_ff @(posedge clk) begin
      wr_ya <= y_wa;
      wr_ca <= c_wa;
`ifdef MCU_BUILDER_420_EN
      wr_first <= c_first;
      wr_mode  <= mode_cur;
`endif
   end

   always_ff @(posedge clk) begin
      if (conv_v) begin
         y_mem[wr_ya] <= conv_y;
`ifdef MCU_BUILDER_420_EN
         // 4:2:0 chroma entries accumulate the four samples of a 2x2 cell.
         if (wr_mode && !wr_first) begin
            cb_mem[wr_ca] <= cb_mem[wr_ca] + cb_ext;
            cr_mem[wr_ca] <= cr_mem[wr_ca] + cr_ext;
         end else begin
            cb_mem[wr_ca] <= cb_ext;
            cr_mem[wr_ca] <= cr_ext;
         end
`else
         cb_mem[wr_ca] <= conv_cb;
         cr_mem[wr_ca] <= conv_cr;
`endif
      end
   end

   always_comb begin
      smp_nxt     = (state == ST_DRAIN) ? smp_cnt + 9'd1 : 9'd0;
      c_blk       = mode_m ? 3'd4 : 3'd1;
      rd_tag.pos  = smp_nxt[5:0];
      rd_tag.idx  = 2'd0;
      rd_tag.comp = COMP_Y;
      if (smp_nxt[8:6] == c_blk)     rd_tag.comp = COMP_CB;
      else if (smp_nxt[8:6] > c_blk) rd_tag.comp = COMP_CR;
      else                           rd_tag.idx  = smp_nxt[7:6];
      y_rd  = y_mem[smp_nxt[PC_W-1:0]];
      c_sel = (rd_tag.comp == COMP_CB) ? cb_mem[rd_tag.pos] : cr_mem[rd_tag.pos];
`ifdef MCU_BUILDER_420_EN
      c_avg = (12'(c_sel) + 12'sd2) >>> 2;
      c_s8  = mode_m ? sat8(c_avg) : c_sel[7:0];
`else
      c_s8  = c_sel;
`endif
      rd_s8 = (rd_tag.comp == COMP_Y) ? y_rd : c_s8;
   end

   assign smp_last = (smp_cnt == (mode_m ? 9'(MCU420_SMP - 1) : 9'(MCU444_SMP - 1)));

   always_ff @(posedge clk) begin
      if (rst) begin
         state    <= ST_FILL;
         pix_cnt  <= '0;
         smp_cnt  <= '0;
         mcu_done <= 1'b0;
         blk_data <= '0;
         blk_comp <= '0;
         blk_idx  <= '0;
         blk_pos  <= '0;
         blk_last <= 1'b0;
      end else begin
         mcu_done <= 1'b0;
         case (state)
            ST_FILL: if (pix_fire) begin
               pix_cnt <= pix_last ? '0 : pix_cnt + 1'b1;
               if (pix_last) state <= ST_SETTLE;
            end
            // SETTLE lets the final converted pixel land in the buffers.
            ST_SETTLE: state <= ST_PRIME;
            ST_PRIME, ST_DRAIN: begin
               if (state == ST_PRIME || blk_ready) begin
                  if (state == ST_DRAIN && smp_last) begin
                     state    <= ST_FILL;
                     mcu_done <= 1'b1;
                     blk_last <= 1'b0;
                  end else begin
                     state    <= ST_DRAIN;
                     smp_cnt  <= smp_nxt;
                     blk_data <= {{8{rd_s8[7]}}, rd_s8};
                     blk_comp <= rd_tag.comp;
                     blk_idx  <= rd_tag.idx;
                     blk_pos  <= rd_tag.pos;
                     blk_last <= (rd_tag.pos == 6'd63);
                  end
               end
            end
            default: state <= ST_FILL;
         endcase
      end
   end

endmodule

// File: tb/tb_mcu_builder.sv
// Directed bench for mcu_builder; the 4:2:0 ramp runs when MCU_BUILDER_420_EN
// is defined, otherwise mode_420=1 is checked to behave as 4:4:4.
`timescale 1ns/1ps
module tb_mcu_builder;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        mode_420 = 1'b0;
   logic [7:0]  pix_r = '0, pix_g = '0, pix_b = '0;
   logic        pix_valid = 1'b0;
   logic        pix_ready;
   logic [15:0] blk_data;
   logic [1:0]  blk_comp, blk_idx, fsm_state;
   logic [5:0]  blk_pos;
   logic        blk_valid, blk_last, mcu_done;
   logic        blk_ready = 1'b0;

   int          tests = 0;
   int          fails = 0;
   logic [26:0] exp_q[$];

   always #5 clk = ~clk;

   mcu_builder dut (
      .clk       (clk),
      .rst       (rst),
      .mode_420  (mode_420),
      .pix_r     (pix_r),
      .pix_g     (pix_g),
      .pix_b     (pix_b),
      .pix_valid (pix_valid),
      .pix_ready (pix_ready),
      .blk_data  (blk_data),
      .blk_comp  (blk_comp),
      .blk_idx   (blk_idx),
      .blk_pos   (blk_pos),
      .blk_valid (blk_valid),
      .blk_ready (blk_ready),
      .blk_last  (blk_last),
      .mcu_done  (mcu_done),
      .fsm_state (fsm_state)
   );

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      tests++;
      assert (obs === exp) else begin
         fails++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   function automatic logic [26:0] smp(input int comp, input int idx, input int pos, input int val);
      return {(pos == 63), 2'(comp), 2'(idx), 6'(pos), 16'(val)};
   endfunction

   function automatic logic [26:0] outs();
      return {blk_last, blk_comp, blk_idx, blk_pos, blk_data};
   endfunction

   task automatic push_blk(input int comp, input int idx, input int val);
      for (int p = 0; p < 64; p++) exp_q.push_back(smp(comp, idx, p, val));
   endtask

   task automatic send_px(input logic [7:0] r, input logic [7:0] g, input logic [7:0] b, input logic m);
      int guard = 0;
      @(negedge clk);
      while (!pix_ready && guard < 2000) begin
         @(negedge clk);
         guard++;
      end
      if (guard >= 2000) chk("pix_ready_timeout", 32'd0, 32'd1);
      pix_r = r; pix_g = g; pix_b = b; mode_420 = m; pix_valid = 1'b1;
      @(posedge clk);
   endtask

   task automatic px_idle();
      @(negedge clk);
      pix_valid = 1'b0;
   endtask

   task automatic chk_reset_state();
      chk("rst_pix_ready", pix_ready, 1);
      chk("rst_blk_valid", blk_valid, 0);
      chk("rst_blk_last", blk_last, 0);
      chk("rst_mcu_done", mcu_done, 0);
      chk("rst_blk_data", blk_data, 0);
      chk("rst_blk_comp", blk_comp, 0);
      chk("rst_blk_idx", blk_idx, 0);
      chk("rst_blk_pos", blk_pos, 0);
   endtask

   // Called at a falling edge; consumes n samples against exp_q.
   task automatic drain(input int n, input int stall_at);
      int got = 0;
      int guard = 0;
      blk_ready = 1'b1;
      while (got < n && guard < 5000) begin
         if (blk_valid) begin
            if (got == stall_at) begin
               blk_ready = 1'b0;
               for (int k = 0; k < 10; k++) begin
                  @(negedge clk);
                  chk("stall_outputs", outs(), exp_q[0]);
                  chk("stall_blk_valid", blk_valid, 1);
                  chk("stall_pix_ready", pix_ready, 0);
               end
               blk_ready = 1'b1;
            end
            if (exp_q.size() == 0) chk("extra_sample", 32'd1, 32'd0);
            else                   chk("sample", outs(), exp_q.pop_front());
            got++;
         end
         @(negedge clk);
         guard++;
      end
      chk("sample_count", got, n);
      chk("mcu_done_pulse", mcu_done, 1);
      chk("pix_ready_after", pix_ready, 1);
      chk("blk_valid_after", blk_valid, 0);
      @(negedge clk);
      chk("mcu_done_clear", mcu_done, 0);
   endtask

   initial begin
      repeat (3) @(posedge clk);
      @(negedge clk);
      rst = 1'b0;
      chk_reset_state();

      // White 4:4:4 block, with blk_valid latency check.
      exp_q.delete();
      push_blk(0, 0, 127); push_blk(1, 0, 0); push_blk(2, 0, 0);
      for (int p = 0; p < 64; p++) send_px(8'd255, 8'd255, 8'd255, 1'b0);
      px_idle();
      chk("lat_half", blk_valid, 0);
      @(negedge clk);
      chk("lat_one", blk_valid, 0);
      @(negedge clk);
      chk("lat_two", blk_valid, 1);
      drain(192, -1);

      // Pure red, Cr saturates from 128; stall at Cb position 30.
      exp_q.delete();
      push_blk(0, 0, -52); push_blk(1, 0, -43); push_blk(2, 0, 127);
      for (int p = 0; p < 64; p++) send_px(8'd255, 8'd0, 8'd0, 1'b0);
      px_idle();
      drain(192, 64 + 30);

      // Reset in the middle of FILL discards the partial MCU.
      for (int p = 0; p < 30; p++)
         send_px(8'($urandom_range(0, 255)), 8'($urandom_range(0, 255)), 8'($urandom_range(0, 255)), 1'b0);
      @(negedge clk);
      pix_valid = 1'b0;
      rst = 1'b1;
      repeat (2) @(negedge clk);
      rst = 1'b0;
      chk_reset_state();
      exp_q.delete();
      push_blk(0, 0, 127); push_blk(1, 0, 0); push_blk(2, 0, 0);
      for (int p = 0; p < 64; p++) send_px(8'd255, 8'd255, 8'd255, 1'b0);
      px_idle();
      drain(192, -1);
      repeat (4) @(negedge clk);
      chk("no_second_mcu", blk_valid, 0);

`ifdef MCU_BUILDER_420_EN
      // Grey ramp, 4:2:0 latched on the first pixel then mode_420 dropped.
      exp_q.delete();
      for (int b = 0; b < 4; b++)
         for (int p = 0; p < 64; p++)
            exp_q.push_back(smp(0, b, p,
               ((b / 2) * 8 + p / 8) * 16 + (b % 2) * 8 + p % 8 - 128));
      push_blk(1, 0, 0); push_blk(2, 0, 0);
      for (int p = 0; p < 256; p++)
         send_px(8'(p), 8'(p), 8'(p), (p == 0));
      px_idle();
      drain(384, -1);
`else
      // mode_420 has no effect in this build: checkerboard by pixel parity.
      exp_q.delete();
      for (int p = 0; p < 64; p++) exp_q.push_back(smp(0, 0, p, (p % 2 == 0) ? 127 : -128));
      push_blk(1, 0, 0); push_blk(2, 0, 0);
      for (int p = 0; p < 64; p++) begin
         if (p % 2 == 0) send_px(8'd255, 8'd255, 8'd255, 1'b1);
         else            send_px(8'd0, 8'd0, 8'd0, 1'b1);
      end
      px_idle();
      drain(192, -1);
`endif

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
